// File: rtl/alu.sv
// alu -- registered SIZE-bit ALU for the Salamander-4 datapath.
//
// Computes one operation per enabled clock on operand L (accumulator side)
// and operand R (register file side, also the shift amount). The result and
// the carry/borrow/shift-out flag are both registered, so latency is one clock.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rstn           synchronous active-low reset, has priority over CE
//   CE             clock enable: 1 = load new result, 0 = hold
//   OP_CODE        operation select (see localparams below)
//   left_operand   operand L
//   right_operand  operand R, full width is used as the shift amount
//   carry_in       carry/borrow in, only used by ADD and SUB
//   carry_out      registered carry/borrow/shift-out flag
//   op_out         registered result
module alu #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            CE,
  input  logic [3:0]      OP_CODE,
  input  logic [SIZE-1:0] left_operand,
  input  logic [SIZE-1:0] right_operand,
  input  logic            carry_in,
  output logic            carry_out,
  output logic [SIZE-1:0] op_out
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_ST  = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  // SIZE always fits in SIZE bits because 2^SIZE > SIZE.
  localparam logic [SIZE-1:0] SIZE_V = SIZE[SIZE-1:0];

  logic [SIZE:0]     add_sum;
  logic [SIZE:0]     sub_diff;
  logic [SIZE:0]     inc_sum;
  logic [SIZE:0]     dec_diff;
  logic [2*SIZE-1:0] shl_wide;
  logic [2*SIZE-1:0] shr_wide;
  logic              shift_zero;
  logic              shift_over;
  logic [SIZE-1:0]   next_result;
  logic              next_carry;

  // Arithmetic is done one bit wider so the top bit is the carry, or the
  // borrow for subtraction (a negative difference sets the extra MSB).
  always_comb begin
    add_sum  = {1'b0, left_operand} + {1'b0, right_operand} + {{SIZE{1'b0}}, carry_in};
    sub_diff = {1'b0, left_operand} - {1'b0, right_operand} - {{SIZE{1'b0}}, carry_in};
    inc_sum  = {1'b0, left_operand} + {{SIZE{1'b0}}, 1'b1};
    dec_diff = {1'b0, left_operand} - {{SIZE{1'b0}}, 1'b1};
  end

  // Shifts run in a double-width window: for 1..SIZE the bit just past the
  // result boundary is exactly the last bit shifted out (L[SIZE-R] for left,
  // L[R-1] for right). Amounts above SIZE are forced to zero explicitly.
  always_comb begin
    shl_wide   = {{SIZE{1'b0}}, left_operand} << right_operand;
    shr_wide   = {left_operand, {SIZE{1'b0}}} >> right_operand;
    shift_zero = (right_operand == '0);
    shift_over = (right_operand > SIZE_V);
  end

  // Next-state selection, purely from the current inputs.
  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    case (OP_CODE)
      OP_ADD: {next_carry, next_result} = add_sum;
      OP_SUB: {next_carry, next_result} = sub_diff;
      OP_AND: next_result = left_operand & right_operand;
      OP_OR:  next_result = left_operand | right_operand;
      OP_XOR: next_result = left_operand ^ right_operand;
      OP_NOT: next_result = ~left_operand;
      OP_LD:  next_result = right_operand;
      OP_ST:  next_result = left_operand;
      OP_INC: {next_carry, next_result} = inc_sum;
      OP_DEC: {next_carry, next_result} = dec_diff;
      OP_SHL: begin
        if (shift_zero) begin
          next_result = left_operand;
        end else if (!shift_over) begin
          next_result = shl_wide[SIZE-1:0];
          next_carry  = shl_wide[SIZE];
        end
      end
      OP_SHR: begin
        if (shift_zero) begin
          next_result = left_operand;
        end else if (!shift_over) begin
          next_result = shr_wide[2*SIZE-1:SIZE];
          next_carry  = shr_wide[SIZE-1];
        end
      end
      default: begin
        next_result = '0;
        next_carry  = 1'b0;
      end
    endcase
  end

  // Output registers: reset wins over enable, disabled edges hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_out    <= '0;
      carry_out <= 1'b0;
    end else if (CE) begin
      op_out    <= next_result;
      carry_out <= next_carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed self-checking bench for the 8-bit alu.
module tb_alu;

  logic       clk;
  logic       rstn;
  logic       CE;
  logic [3:0] OP_CODE;
  logic [7:0] left_operand;
  logic [7:0] right_operand;
  logic       carry_in;
  logic       carry_out;
  logic [7:0] op_out;

  int assertCount;
  int failCount;

  alu #(.SIZE(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .CE           (CE),
    .OP_CODE      (OP_CODE),
    .left_operand (left_operand),
    .right_operand(right_operand),
    .carry_in     (carry_in),
    .carry_out    (carry_out),
    .op_out       (op_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let it pass one rising edge, then settle 1ns.
  task automatic applyStimulus(input logic ce, input logic [3:0] op,
                               input logic [7:0] l, input logic [7:0] r,
                               input logic cin);
    CE            = ce;
    OP_CODE       = op;
    left_operand  = l;
    right_operand = r;
    carry_in      = cin;
    @(posedge clk);
    #1;
  endtask

  // Compare {carry_out, op_out} against the hand-computed value.
  task automatic checkOutput(input string tag, input logic [8:0] actual,
                             input logic [8:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got c=%0b r=0x%02h, expected c=%0b r=0x%02h",
               tag, actual[8], actual[7:0], expected[8], expected[7:0]);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rstn = 1'b0;
    CE = 1'b0; OP_CODE = 4'd0; left_operand = 8'h00; right_operand = 8'h00; carry_in = 1'b0;

    // Reset for two clocks, then hold with CE=0 while an ADD is presented.
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    checkOutput("reset", {carry_out, op_out}, 9'h000);
    rstn = 1'b1;
    applyStimulus(1'b0, 4'd0, 8'h01, 8'h01, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h01, 8'h01, 1'b0);
    checkOutput("hold_after_reset", {carry_out, op_out}, 9'h000);

    // Arithmetic
    applyStimulus(1'b1, 4'd0, 8'h01, 8'h01, 1'b0); checkOutput("add_1_1",     {carry_out, op_out}, {1'b0, 8'h02});
    applyStimulus(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0); checkOutput("add_ff_1",    {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd0, 8'h01, 8'h01, 1'b1); checkOutput("add_cin",     {carry_out, op_out}, {1'b0, 8'h03});
    applyStimulus(1'b1, 4'd1, 8'h02, 8'h01, 1'b0); checkOutput("sub_2_1",     {carry_out, op_out}, {1'b0, 8'h01});
    applyStimulus(1'b1, 4'd1, 8'h00, 8'h01, 1'b0); checkOutput("sub_0_1",     {carry_out, op_out}, {1'b1, 8'hFF});
    applyStimulus(1'b1, 4'd1, 8'h05, 8'h02, 1'b1); checkOutput("sub_cin",     {carry_out, op_out}, {1'b0, 8'h02});
    applyStimulus(1'b1, 4'd1, 8'h02, 8'h02, 1'b1); checkOutput("sub_cin_bor", {carry_out, op_out}, {1'b1, 8'hFF});
    applyStimulus(1'b1, 4'd8, 8'h01, 8'h00, 1'b1); checkOutput("inc_1",       {carry_out, op_out}, {1'b0, 8'h02});
    applyStimulus(1'b1, 4'd8, 8'hFF, 8'h00, 1'b0); checkOutput("inc_ff",      {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd9, 8'h80, 8'h00, 1'b1); checkOutput("dec_80",      {carry_out, op_out}, {1'b0, 8'h7F});
    applyStimulus(1'b1, 4'd9, 8'h00, 8'h00, 1'b0); checkOutput("dec_0",       {carry_out, op_out}, {1'b1, 8'hFF});

    // Logic and pass-through; carry_in set to show it is ignored
    applyStimulus(1'b1, 4'd3, 8'hAA, 8'h55, 1'b1); checkOutput("or",  {carry_out, op_out}, {1'b0, 8'hFF});
    applyStimulus(1'b1, 4'd4, 8'hAA, 8'h55, 1'b1); checkOutput("xor", {carry_out, op_out}, {1'b0, 8'hFF});
    applyStimulus(1'b1, 4'd5, 8'hAA, 8'h55, 1'b1); checkOutput("not", {carry_out, op_out}, {1'b0, 8'h55});
    applyStimulus(1'b1, 4'd6, 8'hAA, 8'h55, 1'b1); checkOutput("ld",  {carry_out, op_out}, {1'b0, 8'h55});
    applyStimulus(1'b1, 4'd7, 8'hAA, 8'h55, 1'b1); checkOutput("st",  {carry_out, op_out}, {1'b0, 8'hAA});
    applyStimulus(1'b1, 4'd2, 8'hFF, 8'h55, 1'b0); checkOutput("and", {carry_out, op_out}, {1'b0, 8'h55});
    applyStimulus(1'b1, 4'd2, 8'hAA, 8'h55, 1'b0); checkOutput("and_disjoint", {carry_out, op_out}, {1'b0, 8'h00});

    // Shifts, including amount boundaries 0, SIZE, SIZE+1 and a large amount
    applyStimulus(1'b1, 4'd10, 8'h10, 8'h01, 1'b1); checkOutput("shl_10_1", {carry_out, op_out}, {1'b0, 8'h20});
    applyStimulus(1'b1, 4'd11, 8'h10, 8'h01, 1'b1); checkOutput("shr_10_1", {carry_out, op_out}, {1'b0, 8'h08});
    applyStimulus(1'b1, 4'd10, 8'h80, 8'h01, 1'b0); checkOutput("shl_80_1", {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd11, 8'h01, 8'h01, 1'b0); checkOutput("shr_01_1", {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd10, 8'h0B, 8'h03, 1'b0); checkOutput("shl_0b_3", {carry_out, op_out}, {1'b0, 8'h58});
    applyStimulus(1'b1, 4'd11, 8'hB4, 8'h03, 1'b0); checkOutput("shr_b4_3", {carry_out, op_out}, {1'b1, 8'h16});
    applyStimulus(1'b1, 4'd10, 8'h5A, 8'h00, 1'b0); checkOutput("shl_r0",   {carry_out, op_out}, {1'b0, 8'h5A});
    applyStimulus(1'b1, 4'd11, 8'hA5, 8'h00, 1'b0); checkOutput("shr_r0",   {carry_out, op_out}, {1'b0, 8'hA5});
    applyStimulus(1'b1, 4'd10, 8'h01, 8'h08, 1'b0); checkOutput("shl_r8",   {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd11, 8'h80, 8'h08, 1'b0); checkOutput("shr_r8",   {carry_out, op_out}, {1'b1, 8'h00});
    applyStimulus(1'b1, 4'd10, 8'hFF, 8'h09, 1'b0); checkOutput("shl_r9",   {carry_out, op_out}, {1'b0, 8'h00});
    applyStimulus(1'b1, 4'd11, 8'hFF, 8'h09, 1'b0); checkOutput("shr_r9",   {carry_out, op_out}, {1'b0, 8'h00});
    applyStimulus(1'b1, 4'd10, 8'hFF, 8'h11, 1'b0); checkOutput("shl_r11",  {carry_out, op_out}, {1'b0, 8'h00});
    applyStimulus(1'b1, 4'd11, 8'hFF, 8'h81, 1'b0); checkOutput("shr_r81",  {carry_out, op_out}, {1'b0, 8'h00});

    // Reserved opcodes clear the result and carry
    applyStimulus(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    applyStimulus(1'b1, 4'd12, 8'hAA, 8'h55, 1'b1); checkOutput("rsv_12", {carry_out, op_out}, 9'h000);
    applyStimulus(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    applyStimulus(1'b1, 4'd15, 8'hAA, 8'h55, 1'b1); checkOutput("rsv_15", {carry_out, op_out}, 9'h000);

    // Enable and feedback: result routed back as R between edges
    applyStimulus(1'b1, 4'd0, 8'h01, 8'h01, 1'b0); checkOutput("fb_first", {carry_out, op_out}, {1'b0, 8'h02});
    applyStimulus(1'b1, 4'd0, 8'h01, op_out, 1'b0); checkOutput("fb_second", {carry_out, op_out}, {1'b0, 8'h03});
    applyStimulus(1'b0, 4'd0, 8'hFF, 8'hFF, 1'b1); checkOutput("ce_freeze", {carry_out, op_out}, {1'b0, 8'h03});
    applyStimulus(1'b0, 4'd8, 8'hFF, 8'h00, 1'b0); checkOutput("ce_freeze2", {carry_out, op_out}, {1'b0, 8'h03});
    rstn = 1'b0;
    applyStimulus(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0); checkOutput("reset_over_ce", {carry_out, op_out}, 9'h000);
    rstn = 1'b1;
    applyStimulus(1'b1, 4'd7, 8'h3C, 8'h00, 1'b0); checkOutput("after_reset", {carry_out, op_out}, {1'b0, 8'h3C});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
